// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks one 128-bit block through the initial
// AddRoundKey load and NUM_ROUNDS feedback rounds, captures the ciphertext
// from the round register and hands it to the consumer over valid/ready.
// One block is in flight at a time; abort returns to IDLE from any state.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_W    = 4,
  parameter int DATA_W     = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                abort,
  input  logic [DATA_W-1:0]   a_out,
  output logic                d_tk,
  output logic                round_en,
  output logic [ROUND_W-1:0]  round_num,
  output logic                last_round,
  output logic [DATA_W-1:0]   ct_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUND   = 2'd1,
    CAPTURE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_RN = ROUND_W'(NUM_ROUNDS);

  state_t state;

  // Round index advance; the final round index is held, never wrapped.
  function automatic logic [ROUND_W-1:0] next_round(input logic [ROUND_W-1:0] rn);
    if (rn >= LAST_RN) begin
      return LAST_RN;
    end
    return rn + ROUND_W'(1);
  endfunction

  // Datapath strobes decoded from registered state; only the IDLE accept
  // path looks at the live handshake inputs.
  always_comb begin
    in_ready   = 1'b0;
    round_en   = 1'b0;
    d_tk       = 1'b0;
    last_round = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          round_en = in_valid & ~abort;
        end
        ROUND: begin
          d_tk       = 1'b1;
          busy       = 1'b1;
          round_en   = ~abort;
          last_round = (round_num == LAST_RN);
        end
        default: begin
          d_tk = 1'b1;
          busy = 1'b1;
        end
      endcase
    end
  end

  // State, round index, ciphertext capture and output-valid sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_num <= '0;
      ct_out    <= '0;
      out_valid <= 1'b0;
    end else if (abort) begin
      // abort wins over every transition, including an OUTPUT handshake
      state     <= IDLE;
      round_num <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          round_num <= '0;
          if (in_valid) begin
            state     <= ROUND;
            round_num <= ROUND_W'(1);
          end
        end
        ROUND: begin
          if (round_num == LAST_RN) begin
            state <= CAPTURE;
          end else begin
            round_num <= next_round(round_num);
          end
        end
        CAPTURE: begin
          ct_out    <= a_out;
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round_num <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          round_num <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a 10-round and a 14-round instance share the
// same stimulus; a cycle-level model of each is compared every cycle, with
// directed scenarios adding literal timing and data expectations.
module tb_aes_round_ctrl;

  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] a_out = '0;

  logic         in_ready_w [2];
  logic         d_tk_w     [2];
  logic         round_en_w [2];
  logic [3:0]   rn_w       [2];
  logic         last_w     [2];
  logic [127:0] ct_w       [2];
  logic         ov_w       [2];
  logic         busy_w     [2];

  int passed = 0;
  int total  = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_W(4), .DATA_W(128)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .abort(abort), .a_out(a_out), .d_tk(d_tk_w[0]), .round_en(round_en_w[0]),
    .round_num(rn_w[0]), .last_round(last_w[0]), .ct_out(ct_w[0]),
    .out_valid(ov_w[0]), .out_ready(out_ready), .busy(busy_w[0])
  );

  aes_round_ctrl #(.NUM_ROUNDS(14), .ROUND_W(4), .DATA_W(128)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .abort(abort), .a_out(a_out), .d_tk(d_tk_w[1]), .round_en(round_en_w[1]),
    .round_num(rn_w[1]), .last_round(last_w[1]), .ct_out(ct_w[1]),
    .out_valid(ov_w[1]), .out_ready(out_ready), .busy(busy_w[1])
  );

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endfunction

  // Model: a block is "busy" from acceptance until handshake; k counts
  // cycles since acceptance (1..N rounds, N+1 capture, N+2.. output).
  int           nr   [2] = '{10, 14};
  bit           m_busy [2] = '{1'b0, 1'b0};
  int           m_k    [2] = '{0, 0};
  logic [127:0] m_ct   [2] = '{128'h0, 128'h0};

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        bit   b;
        int   k;
        int   n;
        logic e_en;
        int   e_rn;
        b = m_busy[i];
        k = m_k[i];
        n = nr[i];
        e_en = !rst && (b ? (k >= 1 && k <= n && !abort) : (in_valid && !abort));
        e_rn = b ? ((k > n) ? n : k) : 0;
        check($sformatf("in_ready[%0d]", i),  128'(in_ready_w[i]), 128'(!rst && !b));
        check($sformatf("round_en[%0d]", i),  128'(round_en_w[i]), 128'(e_en));
        check($sformatf("d_tk[%0d]", i),      128'(d_tk_w[i]),     128'(!rst && b));
        check($sformatf("last[%0d]", i),      128'(last_w[i]),     128'(!rst && b && k == n));
        check($sformatf("busy[%0d]", i),      128'(busy_w[i]),     128'(!rst && b));
        check($sformatf("round_num[%0d]", i), 128'(rn_w[i]),       128'(e_rn));
        check($sformatf("out_valid[%0d]", i), 128'(ov_w[i]),       128'(b && k == n + 2));
        check($sformatf("ct_out[%0d]", i),    ct_w[i],             m_ct[i]);
        // advance to the state the next clock edge produces
        if (rst) begin
          m_busy[i] = 1'b0; m_k[i] = 0; m_ct[i] = '0;
        end else if (abort) begin
          m_busy[i] = 1'b0; m_k[i] = 0;
        end else if (!b) begin
          if (in_valid) begin
            m_busy[i] = 1'b1; m_k[i] = 1;
          end
        end else if (k <= n) begin
          m_k[i] = k + 1;
        end else if (k == n + 1) begin
          m_ct[i] = a_out;
          m_k[i]  = n + 2;
        end else if (out_ready) begin
          m_busy[i] = 1'b0; m_k[i] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles from an accept (cycle 0 = current cycle already driven)
  // until both instances raise out_valid; records first last_round cycles.
  task automatic measure(output int t0, output int t1, output int l0, output int l1,
                         output int nl0, output int nl1);
    t0 = 0; t1 = 0; l0 = 0; l1 = 0; nl0 = 0; nl1 = 0;
    tick();
    in_valid = 1'b0;
    for (int lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (last_w[0]) begin nl0++; if (l0 == 0) l0 = lat; end
      if (last_w[1]) begin nl1++; if (l1 == 0) l1 = lat; end
      if (ov_w[0] && t0 == 0) t0 = lat;
      if (ov_w[1] && t1 == 0) t1 = lat;
      if (t0 != 0 && t1 != 0) break;
      tick();
    end
  endtask

  initial begin
    int t0, t1, l0, l1, nl0, nl1;
    int acc [$];
    int hs [$];

    // reset
    tick();
    run = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready",  128'(in_ready_w[0]), 128'(1));
    check("reset busy",      128'(busy_w[0]),     128'(0));
    check("reset round_num", 128'(rn_w[0]),       128'(0));
    check("reset out_valid", 128'(ov_w[0]),       128'(0));
    check("reset ct_out",    ct_w[0],             128'h0);

    // FIPS-197 block; round register output presents the known ciphertext
    tick();
    in_valid = 1'b1;
    a_out    = FIPS_CT;
    @(negedge clk);
    check("accept round_en", 128'(round_en_w[0]), 128'(1));
    check("accept d_tk",     128'(d_tk_w[0]),     128'(0));
    measure(t0, t1, l0, l1, nl0, nl1);
    check("latency10",   128'(t0),  128'(12));
    check("latency14",   128'(t1),  128'(16));
    check("last10 at",   128'(l0),  128'(10));
    check("last14 at",   128'(l1),  128'(14));
    check("last10 count", 128'(nl0), 128'(1));
    check("last14 count", 128'(nl1), 128'(1));
    check("fips ct",     ct_w[0],   FIPS_CT);
    for (int i = 0; i < 5; i++) begin
      tick();
      a_out = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("hold ct",        ct_w[0],             FIPS_CT);
      check("hold out_valid", 128'(ov_w[0]),       128'(1));
      check("hold in_ready",  128'(in_ready_w[0]), 128'(0));
      check("hold busy",      128'(busy_w[0]),     128'(1));
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("post hs in_ready", 128'(in_ready_w[0]), 128'(1));
    check("post hs out_valid", 128'(ov_w[0]),      128'(0));

    // abort at round 4
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort round_num", 128'(rn_w[0]),       128'(4));
    check("abort round_en",  128'(round_en_w[0]), 128'(0));
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("aborted busy",      128'(busy_w[0]), 128'(0));
    check("aborted round_num", 128'(rn_w[0]),   128'(0));
    check("aborted ct kept",   ct_w[0],         FIPS_CT);
    for (int i = 0; i < 20; i++) tick();

    // reset during capture, then a clean block
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    @(negedge clk);
    check("capture cycle round_num", 128'(rn_w[0]), 128'(10));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst ct_out",    ct_w[0],         128'h0);
    check("rst out_valid", 128'(ov_w[0]),   128'(0));
    check("rst busy",      128'(busy_w[0]), 128'(0));
    a_out    = 128'h0123456789abcdeffedcba9876543210;
    in_valid = 1'b1;
    measure(t0, t1, l0, l1, nl0, nl1);
    check("relaunch latency", 128'(t0), 128'(12));
    check("relaunch ct",      ct_w[0],  128'h0123456789abcdeffedcba9876543210);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();

    // back-to-back with in_valid and out_ready tied high
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (in_valid && in_ready_w[0]) acc.push_back(c);
      if (ov_w[0] && out_ready) hs.push_back(c);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b accepts", 128'(acc.size() >= 2), 128'(1));
    check("b2b handshakes", 128'(hs.size() >= 2), 128'(1));
    if (acc.size() >= 2 && hs.size() >= 2) begin
      check("b2b accept gap", 128'(acc[1] - hs[0]), 128'(1));
      check("b2b output gap", 128'(hs[1] - hs[0]),  128'(13));
    end
    for (int i = 0; i < 20; i++) tick();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 127) == 0);
      abort     = ($urandom_range(0, 31) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      a_out     = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences the AES round datapath for one 128-bit block.
- Drives the d_tk select of the input router: 0 selects text/key input, 1 selects round-output feedback.
- Issues round-register enables, the round index and the final-round flag, captures the ciphertext and returns it over a valid/ready handshake.
- Sits between the host interface and the round datapath; one block in flight at a time.

Parameters:
- NUM_ROUNDS, 10, number of rounds after initial AddRoundKey (10/12/14 for AES-128/192/256); legal range 1 to 2^ROUND_W-1.
- ROUND_W, 4, width of round_num.
- DATA_W, 128, block width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  host presents block and key on datapath inputs
- in_ready  output  1  controller can accept a block
- abort  input  1  cancel current operation
- a_out  input  DATA_W  round register output from datapath
- d_tk  output  1  router select: 0 = tk_in, 1 = a_out feedback
- round_en  output  1  load enable for datapath round register
- round_num  output  ROUND_W  current round index to key schedule/datapath
- last_round  output  1  final round; datapath skips MixColumns
- ct_out  output  DATA_W  captured ciphertext, registered
- out_valid  output  1  ct_out valid
- out_ready  input  1  consumer accepts ct_out
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, ROUND, CAPTURE, OUTPUT. Reset value: IDLE.
- Reset (rst=1 at clk edge, any state): state=IDLE, round_num=0, ct_out=0, out_valid=0.
- While rst=1, in_ready, round_en, d_tk, last_round and busy are all 0.
- IDLE:
  - in_ready=1, d_tk=0, busy=0, round_num=0.
  - Accept when in_valid & in_ready & !abort. That cycle: round_en=1, d_tk=0, so the round register loads round-0 (tk_in path).
  - Next state ROUND, round_num<=1.
  - Without acceptance: round_en=0, stay IDLE.
- ROUND:
  - in_ready=0, d_tk=1, round_en=1 every cycle.
  - last_round=1 iff round_num==NUM_ROUNDS, else 0.
  - round_num<NUM_ROUNDS: round_num<=round_num+1, stay.
  - round_num==NUM_ROUNDS: go CAPTURE, round_num held.
  - round_num never wraps; max value NUM_ROUNDS.
- CAPTURE:
  - round_en=0, d_tk=1.
  - ct_out<=a_out at end of cycle; next state OUTPUT.
- OUTPUT:
  - out_valid=1, ct_out stable until handshake.
  - round_en=0, in_ready=0.
  - On out_valid & out_ready: out_valid<=0, round_num<=0, state IDLE.
  - out_ready low holds indefinitely.
- Latency: accept at cycle T; rounds T+1..T+NUM_ROUNDS; capture T+NUM_ROUNDS+1; out_valid first high T+NUM_ROUNDS+2 (T+12 for default).
- Throughput: minimum NUM_ROUNDS+3 cycles per block. There is one IDLE bubble after the output handshake; no overlap of output and next input.
- abort:
  - Highest priority after rst.
  - In ROUND, CAPTURE or OUTPUT: the cycle abort is high has round_en=0 and out_valid held at its registered value. Next state IDLE, round_num=0, out_valid=0.
  - ct_out is not updated on abort (retains previous value).
  - In IDLE, abort blocks acceptance that cycle (round_en=0).
- Simultaneous out_ready and abort in OUTPUT: treated as abort; the consumer must not count the transfer.
- in_valid outside IDLE is ignored; the host must hold data until in_ready.
- d_tk in CAPTURE/OUTPUT is don't-care to the datapath but is driven to 1 for determinism.
- All outputs except in_ready, round_en, d_tk, last_round and busy are registered. Those five are decoded from registered state and rst only, with no combinational path from inputs except round_en in IDLE (in_valid & !abort).

Test Plan:
- Reset then in_valid=1 at cycle T with the FIPS-197 vector (pt 00112233445566778899aabbccddeeff, key 000102…0f) -> round_en high T..T+10, d_tk 0 at T then 1, round_num 1..10, last_round only at T+10, out_valid at T+12 with ct_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Same run with out_ready held low 5 cycles after out_valid -> ct_out and out_valid stable, in_ready=0, busy=1; transfer on first out_ready; in_ready=1 the following cycle.
- abort asserted while round_num=4 -> round_en=0 that cycle, IDLE next cycle, round_num=0, out_valid never asserts, previous ct_out unchanged.
- rst asserted during CAPTURE -> next cycle state IDLE, ct_out=0, out_valid=0; a new block then completes normally in 12 cycles.
- Two back-to-back blocks with out_ready tied 1 and in_valid tied 1 -> second accept exactly 1 cycle after first handshake; outputs 13 cycles apart.
- NUM_ROUNDS=14 build -> round_num reaches 14, last_round only at round 14, out_valid at T+16.
